async_fifo_rd_drain: RTL and testbench

- Read-side consumer of the asynchronous FIFO, in the rclk domain.
- Drives pop against the FIFO read port (pop/rdata/empty) and absorbs the FIFO's fixed read latency.
- Re-presents the words on a valid/ready stream to downstream logic, with full throughput and no lost or duplicated words.
- Counts drained words and reports idle for the test/monitor side.

---
 rtl/async_fifo_rd_drain.sv | 109 ++++++++++
 tb/tb_async_fifo_rd_drain.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_drain.sv
// Read-side drain for the async FIFO: issues credit-limited pops, absorbs the
// fixed read latency in a small skid buffer and re-presents words as a stream.
module async_fifo_rd_drain #(
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 1,
  parameter int CWIDTH = 16
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              empty,
  output logic              pop,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              drain_en,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] pop_cnt,
  output logic              idle
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int OW    = $clog2(DEPTH + 1);
  localparam logic [OW:0]   DEPTH_W  = (OW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [CWIDTH-1:0] pop_cnt_q, pop_cnt_d;

  logic [OW-1:0] inflight;
  logic          capture;
  logic          xfer;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OW'(vld_q[i]);
    end
  end

  // Every word already popped has a reserved slot, so a capture never overflows
  // the buffer and pop has no path from out_ready.
  assign pop = drain_en & ~empty & ~reset &
               (({1'b0, occ_q} + {1'b0, inflight}) < DEPTH_W);

  // Stream handshake: a word moves on an rclk edge where out_valid and out_ready
  // are both high; while out_valid=1 and out_ready=0, out_valid/out_data hold.
  assign out_valid = (occ_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign xfer      = out_valid & out_ready;
  assign capture   = vld_q[RD_LAT-1];
  assign idle      = (occ_q == '0) && (inflight == '0);
  assign pop_cnt   = pop_cnt_q;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = pop;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (capture) begin
      mem_d[wptr_q] = rdata;
      wptr_d        = next_ptr(wptr_q);
    end

    rptr_d = xfer ? next_ptr(rptr_q) : rptr_q;

    unique case ({capture, xfer})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    pop_cnt_d = pop_cnt_q + CWIDTH'(pop);
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q    <= '0;
      wptr_q    <= '0;
      occ_q     <= '0;
      vld_q     <= '0;
      pop_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      occ_q     <= occ_d;
      vld_q     <= vld_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Directed bench for async_fifo_rd_drain: RD_LAT=1 and RD_LAT=2 instances fed
// by small FIFO models, plus a narrow-counter instance for pop_cnt wrap.
module tb_async_fifo_rd_drain;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic reset;
  int   total = 0;
  int   bad   = 0;

  // instance A: RD_LAT=1
  logic       a_empty, a_pop, a_drain, a_valid, a_ready, a_idle, a_force;
  logic [7:0] a_rdata, a_data;
  logic [15:0] a_cnt;
  logic [7:0] a_mem [0:31];
  int         a_head = 0, a_tail = 0, a_xfers = 0;
  logic [7:0] a_exp_q [$];
  logic [7:0] a_e;

  // instance B: RD_LAT=2
  logic       b_empty, b_pop, b_drain, b_valid, b_ready, b_idle;
  logic [7:0] b_rdata, b_data, b_d1;
  logic [15:0] b_cnt;
  logic [7:0] b_mem [0:31];
  int         b_head = 0, b_tail = 0, b_xfers = 0;
  logic [7:0] b_exp_q [$];
  logic [7:0] b_e;

  // instance C: CWIDTH=4
  logic       c_empty, c_pop, c_drain, c_valid, c_ready, c_idle;
  logic [7:0] c_data;
  logic [3:0] c_cnt;

  async_fifo_rd_drain #(.DWIDTH(8), .RD_LAT(1), .CWIDTH(16)) u_a (
    .rclk(rclk), .reset(reset), .empty(a_empty), .pop(a_pop), .rdata(a_rdata),
    .drain_en(a_drain), .out_valid(a_valid), .out_data(a_data),
    .out_ready(a_ready), .pop_cnt(a_cnt), .idle(a_idle)
  );

  async_fifo_rd_drain #(.DWIDTH(8), .RD_LAT(2), .CWIDTH(16)) u_b (
    .rclk(rclk), .reset(reset), .empty(b_empty), .pop(b_pop), .rdata(b_rdata),
    .drain_en(b_drain), .out_valid(b_valid), .out_data(b_data),
    .out_ready(b_ready), .pop_cnt(b_cnt), .idle(b_idle)
  );

  async_fifo_rd_drain #(.DWIDTH(8), .RD_LAT(1), .CWIDTH(4)) u_c (
    .rclk(rclk), .reset(reset), .empty(c_empty), .pop(c_pop), .rdata(8'h00),
    .drain_en(c_drain), .out_valid(c_valid), .out_data(c_data),
    .out_ready(c_ready), .pop_cnt(c_cnt), .idle(c_idle)
  );

  // FIFO models: one-cycle and two-cycle read latency, reset with the drain
  assign a_empty = (a_head == a_tail) || a_force;
  always @(posedge rclk or posedge reset) begin
    if (reset) begin
      a_head  <= 0;
      a_rdata <= 8'h00;
    end else if (a_pop) begin
      a_rdata <= a_mem[a_head];
      a_head  <= a_head + 1;
    end
  end

  assign b_empty = (b_head == b_tail);
  always @(posedge rclk or posedge reset) begin
    if (reset) begin
      b_head  <= 0;
      b_d1    <= 8'h00;
      b_rdata <= 8'h00;
    end else begin
      if (b_pop) begin
        b_d1   <= b_mem[b_head];
        b_head <= b_head + 1;
      end
      b_rdata <= b_d1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // per-cycle invariants and stream scoreboards
  always @(negedge rclk) begin
    if (!reset) begin
      chk("a_pop_while_empty", 32'(a_pop & a_empty), 0);
      chk("b_pop_while_empty", 32'(b_pop & b_empty), 0);
      chk("b_occ_le_depth", 32'(u_b.occ_q <= 3'd4), 1);
      if (a_valid && a_ready) begin
        a_e = (a_exp_q.size() != 0) ? a_exp_q.pop_front() : 8'hxx;
        chk("a_stream_word", 32'(a_data), 32'(a_e));
        a_xfers++;
      end
      if (b_valid && b_ready) begin
        b_e = (b_exp_q.size() != 0) ? b_exp_q.pop_front() : 8'hxx;
        chk("b_stream_word", 32'(b_data), 32'(b_e));
        b_xfers++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    a_drain = 1'b0; a_ready = 1'b0; a_force = 1'b0;
    b_drain = 1'b0; b_ready = 1'b0;
    c_drain = 1'b0; c_ready = 1'b0; c_empty = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = 8'h00;
      b_mem[i] = 8'h00;
    end
    #1 reset = 1'b1;

    // reset with words available and drain enabled
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = 8'(i + 1);
      a_exp_q.push_back(8'(i + 1));
    end
    a_tail = 16; a_drain = 1'b1; a_ready = 1'b1;
    tick(); #1;
    chk("rst_pop", 32'(a_pop), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_idle", 32'(a_idle), 1);
    tick(); #1;
    chk("rst_pop_hold", 32'(a_pop), 0);
    chk("rst_idle_hold", 32'(a_idle), 1);

    // streaming, RD_LAT=1
    tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("t2_pop", 32'(a_pop), 32'(c < 16));
      chk("t2_valid", 32'(a_valid), 32'(c >= 2 && c < 18));
      if (c >= 2 && c < 18) chk("t2_data", 32'(a_data), c - 1);
      if (c == 0) chk("t2_idle_start", 32'(a_idle), 1);
      tick();
    end
    #1;
    chk("t2_cnt", 32'(a_cnt), 16);
    chk("t2_idle_end", 32'(a_idle), 1);

    // backpressure, RD_LAT=2
    tick();
    for (int i = 0; i < 10; i++) begin
      b_mem[i] = 8'(i + 1);
      b_exp_q.push_back(8'(i + 1));
    end
    b_tail = 10; b_ready = 1'b0; b_drain = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("t3_pop", 32'(b_pop), 32'(c < 4));
      chk("t3_valid", 32'(b_valid), 32'(c >= 3));
      if (c >= 3) chk("t3_data_hold", 32'(b_data), 'h01);
      tick();
    end
    #1;
    chk("t3_cnt_stalled", 32'(b_cnt), 4);
    b_ready = 1'b1;
    repeat (24) tick();
    #1;
    chk("t3_cnt", 32'(b_cnt), 10);
    chk("t3_idle", 32'(b_idle), 1);
    chk("t3_sb_left", 32'(b_exp_q.size()), 0);
    chk("t3_xfers", 32'(b_xfers), 10);

    // drain_en drop with two words in flight
    tick();
    for (int i = 10; i < 16; i++) b_mem[i] = 8'(i + 1);
    b_exp_q.push_back(8'h0B);
    b_exp_q.push_back(8'h0C);
    b_tail = 16;
    #1;
    chk("t5_pop_c0", 32'(b_pop), 1);
    tick(); #1;
    chk("t5_pop_c1", 32'(b_pop), 1);
    chk("t5_idle_c1", 32'(b_idle), 0);
    tick();
    b_drain = 1'b0;
    #1;
    chk("t5_pop_c2", 32'(b_pop), 0);
    chk("t5_idle_c2", 32'(b_idle), 0);
    tick();
    for (int c = 3; c < 10; c++) begin
      #1;
      chk("t5_pop", 32'(b_pop), 0);
      chk("t5_valid", 32'(b_valid), 32'(c == 3 || c == 4));
      if (c == 3) chk("t5_data_0b", 32'(b_data), 'h0B);
      if (c == 4) chk("t5_data_0c", 32'(b_data), 'h0C);
      chk("t5_idle", 32'(b_idle), 32'(c >= 5));
      tick();
    end
    #1;
    chk("t5_cnt", 32'(b_cnt), 12);
    chk("t5_sb_left", 32'(b_exp_q.size()), 0);

    // empty toggling every other cycle
    tick();
    for (int i = 16; i < 24; i++) begin
      a_mem[i] = 8'(i + 'h11);
      a_exp_q.push_back(8'(i + 'h11));
    end
    a_tail = 24;
    for (int c = 0; c < 30; c++) begin
      a_force = (c % 2 == 0);
      #1;
      if (a_force) chk("t4_pop_masked", 32'(a_pop), 0);
      tick();
    end
    a_force = 1'b0;
    repeat (5) tick();
    #1;
    chk("t4_cnt", 32'(a_cnt), 24);
    chk("t4_idle", 32'(a_idle), 1);
    chk("t4_sb_left", 32'(a_exp_q.size()), 0);

    // reset mid-stream with three words buffered
    tick();
    for (int i = 24; i < 29; i++) a_mem[i] = 8'(i + 'h19);
    a_tail = 29; a_ready = 1'b0;
    repeat (5) tick();
    #1;
    chk("t6_occ", 32'(u_a.occ_q), 3);
    chk("t6_valid_pre", 32'(a_valid), 1);
    chk("t6_data_pre", 32'(a_data), 'h31);
    chk("t6_pop_pre", 32'(a_pop), 0);
    chk("t6_cnt_pre", 32'(a_cnt), 27);
    tick();
    reset = 1'b1;
    a_tail = 0;
    #1;
    chk("t6_valid_rst", 32'(a_valid), 0);
    chk("t6_cnt_rst", 32'(a_cnt), 0);
    chk("t6_idle_rst", 32'(a_idle), 1);
    chk("t6_data_rst", 32'(a_data), 0);
    tick();
    reset = 1'b0;
    a_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t6_valid_post", 32'(a_valid), 0);
      chk("t6_pop_post", 32'(a_pop), 0);
      chk("t6_cnt_post", 32'(a_cnt), 0);
      tick();
    end
    a_mem[0] = 8'h55;
    a_exp_q.push_back(8'h55);
    a_tail = 1;
    repeat (4) tick();
    #1;
    chk("t6_cnt_restart", 32'(a_cnt), 1);
    chk("t6_sb_left", 32'(a_exp_q.size()), 0);
    chk("t6_idle_end", 32'(a_idle), 1);

    // pop_cnt wrap from all-ones to zero
    tick();
    c_drain = 1'b1; c_ready = 1'b1; c_empty = 1'b0;
    #1;
    chk("wrap_cnt_start", 32'(c_cnt), 0);
    chk("wrap_pop", 32'(c_pop), 1);
    repeat (15) tick();
    #1;
    chk("wrap_cnt_max", 32'(c_cnt), 'hF);
    chk("wrap_pop_max", 32'(c_pop), 1);
    tick(); #1;
    chk("wrap_cnt_zero", 32'(c_cnt), 0);
    c_drain = 1'b0;

    chk("a_total_xfers", 32'(a_xfers), 25);
    chk("b_total_xfers", 32'(b_xfers), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
